// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-unit bus bundling the instruction-memory port, the decode handshake and pc control.
interface inst_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_write;
  logic [DATA_W-1:0] imem_dataout;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  modport master (
    input  fetch_en, redirect, redirect_pc, imem_dataout, inst_ready,
    output imem_addr, imem_write, inst_valid, inst_data, inst_pc
  );
  modport slave (
    output fetch_en, redirect, redirect_pc, imem_dataout, inst_ready,
    input  imem_addr, imem_write, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end absorbing 1-cycle memory latency into a credit-guarded output buffer.
module inst_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  logic [ADDR_W-1:0] pc, infl_pc;
  logic              infl;
  logic [DATA_W-1:0] bdata [BUF_DEPTH];
  logic [ADDR_W-1:0] bpc   [BUF_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       occ;
  logic [PW+1:0]     credit;
  logic              pop, push, issue;
  assign pop    = bus.inst_valid && bus.inst_ready;
  assign push   = infl && !bus.redirect;
  // an in-flight read already owns a slot, so it counts against the buffer
  assign credit = {1'b0, occ} + (PW+2)'(infl) - (PW+2)'(pop);
  assign issue  = bus.fetch_en && !bus.redirect && credit < (PW+2)'(BUF_DEPTH);
  assign bus.imem_addr  = pc;
  assign bus.imem_write = 1'b0;
  assign bus.inst_valid = occ != '0;
  assign bus.inst_data  = bdata[head];
  assign bus.inst_pc    = bpc[head];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= ADDR_W'(RESET_PC);
      infl    <= 1'b0;
      infl_pc <= '0;
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bdata[i] <= '0;
        bpc[i]   <= '0;
      end
    end else if (bus.redirect) begin
      pc   <= bus.redirect_pc;
      infl <= 1'b0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_pc <= pc;
        pc      <= pc + 1'b1;
      end
      if (push) begin
        bdata[tail] <= bus.imem_dataout;
        bpc[tail]   <= infl_pc;
        tail        <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch; expected pcs queued from stimulus, popped on each accept.
module tb_inst_fetch;
  logic clk, reset;
  int vecs = 0, errs = 0;
  logic [15:0] exp_q[$];
  inst_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus();
  inst_fetch #(.RESET_PC(16'h0000), .ADDR_W(16), .DATA_W(32), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // memory image: mem[i] = A000_0000 + i, 1-cycle synchronous read
  always_ff @(posedge clk) bus.imem_dataout <= 32'hA000_0000 + {16'h0, bus.imem_addr};

  task automatic load_q(input logic [15:0] start);
    logic [15:0] p = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(p);
      p = p + 16'd1;
    end
  endtask

  task automatic test_reset();
    reset = 1; bus.fetch_en = 1; bus.inst_ready = 1; bus.redirect = 0; bus.redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (bus.inst_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
    vecs++; if (bus.imem_addr !== 16'h0000) begin errs++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_addr); end
    vecs++; if (bus.imem_write !== 1'b0) begin errs++; $display("FAIL reset_write got=%b exp=0", bus.imem_write); end
    vecs++; if (bus.inst_data !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", bus.inst_data); end
    vecs++; if (bus.inst_pc !== 16'h0) begin errs++; $display("FAIL reset_pc got=%h exp=0", bus.inst_pc); end
    load_q(16'h0000);
    reset = 0;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (bus.inst_valid !== (k >= 2)) begin errs++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, bus.inst_valid, k >= 2); end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL stream_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      bus.inst_ready = (i >= 5);
      vecs++;
      if (bus.inst_valid !== 1'b1) begin errs++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, bus.inst_valid); end
      if (i < 5) begin
        vecs++;
        if (bus.inst_pc !== exp_q[0] || bus.imem_addr !== exp_q[0] + 16'd2) begin
          errs++; $display("FAIL bp_hold i=%0d got pc=%h addr=%h exp pc=%h addr=%h", i, bus.inst_pc, bus.imem_addr, exp_q[0], exp_q[0] + 16'd2);
        end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL bp_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_redirect(input logic [15:0] target, input logic rdy, input int n);
    @(posedge clk); #1;
    bus.inst_ready = rdy; bus.redirect = 1; bus.redirect_pc = target;
    if (bus.inst_valid && bus.inst_ready) begin
      vecs++;
      if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0]) begin
        errs++; $display("FAIL redir_pop got pc=%h exp pc=%h", bus.inst_pc, exp_q[0]);
      end
    end
    load_q(target);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus.redirect = 0; bus.inst_ready = 1;
      vecs++;
      if (bus.inst_valid !== (k >= 3)) begin errs++; $display("FAIL redir_valid k=%0d got=%b exp=%b", k, bus.inst_valid, k >= 3); end
      if (k == 1) begin
        vecs++;
        if (bus.imem_addr !== target) begin errs++; $display("FAIL redir_addr got=%h exp=%h", bus.imem_addr, target); end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL redir_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.redirect = 1; bus.redirect_pc = 16'h0100;
    @(posedge clk); #1;
    vecs++;
    if (bus.inst_valid !== 1'b0) begin errs++; $display("FAIL b2b_valid got=%b exp=0", bus.inst_valid); end
    bus.redirect_pc = 16'h0200;
    load_q(16'h0200);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      bus.redirect = 0;
      vecs++;
      if (bus.inst_valid !== (k >= 3)) begin errs++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, bus.inst_valid, k >= 3); end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL b2b_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_fetch_en();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.fetch_en = (i >= 3); bus.inst_ready = 1;
      vecs++;
      if (bus.inst_valid !== (i < 2 || i >= 5)) begin errs++; $display("FAIL fen_valid i=%0d got=%b exp=%b", i, bus.inst_valid, i < 2 || i >= 5); end
      if (i == 2) begin
        vecs++;
        if (bus.imem_addr !== exp_q[0]) begin errs++; $display("FAIL fen_addr got=%h exp=%h", bus.imem_addr, exp_q[0]); end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL fen_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3;
    reset = 1;
    #1;
    vecs++;
    if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 16'h0000) begin
      errs++; $display("FAIL areset got valid=%b addr=%h exp valid=0 addr=0000", bus.inst_valid, bus.imem_addr);
    end
    @(posedge clk); #1;
    reset = 0;
    load_q(16'h0000);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (bus.inst_valid !== (k >= 2)) begin errs++; $display("FAIL areset_valid k=%0d got=%b exp=%b", k, bus.inst_valid, k >= 2); end
      if (bus.inst_valid && bus.inst_ready) begin
        vecs++;
        if (exp_q.size() == 0 || bus.inst_pc !== exp_q[0] || bus.inst_data !== {16'hA000, exp_q[0]}) begin
          errs++; $display("FAIL areset_out got pc=%h data=%h exp pc=%h", bus.inst_pc, bus.inst_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(16'h0040, 1'b0, 8);
    test_redirect(16'hFFFE, 1'b1, 8);
    test_back_to_back();
    test_fetch_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
